// File: rtl/gather_ingress_hub_if.sv
// Switch-facing and gather-PE-facing signals of the ingress hub.
// Channel c occupies bits [c*DW +: DW] of both data buses.
interface gather_ingress_hub_if #(
    parameter int LANES = 4,
    parameter int PORTS = 2,
    parameter int DW    = 32
);
    localparam int CH = LANES * PORTS;

    logic [CH-1:0]    sw_ovld;
    logic [CH*DW-1:0] sw_odata;
    logic [LANES-1:0] sw_bp;
    logic [CH-1:0]    pe_idle;
    logic [CH-1:0]    pe_vld;
    logic [CH*DW-1:0] pe_data;

    modport master (output sw_ovld, sw_odata, pe_idle, input sw_bp, pe_vld, pe_data);
    modport slave  (input sw_ovld, sw_odata, pe_idle, output sw_bp, pe_vld, pe_data);
endinterface

// File: rtl/gather_ingress_hub.sv
// Ingress hub: registers switch output, drops sentinel words, buffers each channel
// in a FWFT FIFO toward its gather PE, and tracks counters, overflow and drain state.
module gather_ingress_hub #(
    parameter int LANES     = 4,
    parameter int PORTS     = 2,
    parameter int DW        = 32,
    parameter int DEPTH     = 32,
    parameter int FULL_TH   = 22,
    parameter int SENT_BITS = 22,
    parameter int QUIET     = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   sys_start,
    gather_ingress_hub_if.slave    bus,
    output logic [31:0]            cnt_in,
    output logic [31:0]            cnt_out,
    output logic [31:0]            cnt_drop,
    output logic [LANES*PORTS-1:0] overflow,
    output logic                   drained
);
    localparam int CH = LANES * PORTS;
    localparam int AW = $clog2(DEPTH);
    localparam int QW = $clog2(QUIET + 1) + 1;

    logic [CH-1:0]         s1_vld;
    logic [CH-1:0][DW-1:0] s1_data;
    logic [CH-1:0][AW:0]   occ;
    logic [CH-1:0]         sent, wr_req, wr_ok, ovf_set, pop, nonempty, pfull;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_vld  <= '0;
            s1_data <= '0;
        end else begin
            s1_vld  <= bus.sw_ovld;
            s1_data <= bus.sw_odata;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [AW-1:0] rd_ptr, wr_ptr;
        logic [AW:0]   occ_q;

        assign occ[c]      = occ_q;
        assign nonempty[c] = occ_q != '0;
        assign sent[c]     = &s1_data[c][SENT_BITS-1:0];
        assign wr_req[c]   = s1_vld[c] & ~sent[c];
        assign pop[c]      = nonempty[c] & bus.pe_idle[c];
        // a full FIFO still takes the word when its head leaves in the same cycle
        assign wr_ok[c]    = wr_req[c] & ((occ_q != (AW+1)'(DEPTH)) | pop[c]);
        assign ovf_set[c]  = wr_req[c] & ~wr_ok[c];
        assign pfull[c]    = occ_q >= (AW+1)'(FULL_TH);

        assign bus.pe_vld[c]            = pop[c];
        assign bus.pe_data[c*DW +: DW]  = nonempty[c] ? mem[rd_ptr] : '0;

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ_q  <= '0;
            end else begin
                if (pop[c])   rd_ptr <= rd_ptr + 1'b1;
                if (wr_ok[c]) wr_ptr <= wr_ptr + 1'b1;
                occ_q <= occ_q + (AW+1)'(wr_ok[c]) - (AW+1)'(pop[c]);
            end
        end

        always_ff @(posedge ap_clk) begin
            if (wr_ok[c]) mem[wr_ptr] <= s1_data[c];
        end
    end

    always_comb begin
        bus.sw_bp = '0;
        for (int p = 0; p < PORTS; p++)
            for (int l = 0; l < LANES; l++)
                bus.sw_bp[l] = bus.sw_bp[l] | pfull[p*LANES + l];
    end

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CH-1:0] v);
        logic [32:0] s;
        s = {1'b0, a};
        for (int i = 0; i < CH; i++) s = s + 33'(v[i]);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_ff @(posedge ap_clk) begin
        if (ap_rst || sys_start) begin
            cnt_in   <= '0;
            cnt_out  <= '0;
            cnt_drop <= '0;
            overflow <= '0;
        end else begin
            cnt_in   <= sat_add(cnt_in, wr_ok);
            cnt_out  <= sat_add(cnt_out, pop);
            cnt_drop <= sat_add(cnt_drop, s1_vld & sent);
            overflow <= overflow | ovf_set;
        end
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_QUIETING, S_DRAINED} state_t;
    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic          quiet_now;

    assign quiet_now = ~|nonempty & ~|s1_vld & ~|bus.sw_ovld;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state   <= S_IDLE;
            qcnt    <= '0;
            drained <= 1'b0;
        end else begin
            state   <= state_n;
            qcnt    <= qcnt_n;
            drained <= state_n == S_DRAINED;
        end
    end

    always_comb begin
        state_n = state;
        qcnt_n  = qcnt;
        if (sys_start) begin
            state_n = S_RUN;
            qcnt_n  = '0;
        end else begin
            case (state)
                S_RUN: if (quiet_now) begin
                    qcnt_n  = QW'(1);
                    state_n = (QUIET <= 1) ? S_DRAINED : S_QUIETING;
                end
                S_QUIETING: if (!quiet_now) begin
                    state_n = S_RUN;
                    qcnt_n  = '0;
                end else begin
                    qcnt_n = qcnt + 1'b1;
                    if (qcnt_n >= QW'(QUIET)) state_n = S_DRAINED;
                end
                S_DRAINED: if (|bus.sw_ovld) begin
                    state_n = S_RUN;
                    qcnt_n  = '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gather_ingress_hub.sv
// Random plus directed bench for gather_ingress_hub against a queue-based reference model.
module tb_gather_ingress_hub;
    localparam int LANES = 4, PORTS = 2, DW = 32, DEPTH = 32, FULL_TH = 22;
    localparam int SENT_BITS = 22, QUIET = 16;
    localparam int CH = LANES * PORTS;
    localparam logic [DW-1:0] SMASK = DW'((64'd1 << SENT_BITS) - 1);

    logic          ap_clk = 1'b0;
    logic          ap_rst, sys_start;
    logic [31:0]   cnt_in, cnt_out, cnt_drop;
    logic [CH-1:0] overflow;
    logic          drained;

    gather_ingress_hub_if #(.LANES(LANES), .PORTS(PORTS), .DW(DW)) bus ();

    gather_ingress_hub #(
        .LANES(LANES), .PORTS(PORTS), .DW(DW), .DEPTH(DEPTH), .FULL_TH(FULL_TH),
        .SENT_BITS(SENT_BITS), .QUIET(QUIET)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .sys_start(sys_start), .bus(bus.slave),
        .cnt_in(cnt_in), .cnt_out(cnt_out), .cnt_drop(cnt_drop),
        .overflow(overflow), .drained(drained)
    );

    always #5 ap_clk = ~ap_clk;

    // reference state: word queues per channel, the S1 copy, counters and drain bookkeeping
    logic [DW-1:0] q [CH][$];
    logic [CH-1:0] m_s1v = '0;
    logic [DW-1:0] m_s1d [CH];
    longint        m_in = 0, m_out = 0, m_drop = 0;
    logic [CH-1:0] m_ovf = '0;
    bit            m_started = 0;
    int            m_quiet = 0;
    int            total = 0, bad = 0;

    task automatic chk(input string tag, input logic [CH*DW-1:0] act, input logic [CH*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    task automatic tick();
        logic [CH-1:0]    e_vld;
        logic [CH*DW-1:0] e_data;
        logic [LANES-1:0] e_bp;
        logic [31:0]      e_in, e_out, e_drop;
        bit               idle_now;
        int               n_in, n_out, n_drop;
        @(negedge ap_clk);
        e_vld = '0; e_data = '0; e_bp = '0;
        for (int c = 0; c < CH; c++) begin
            if (q[c].size() > 0) begin
                e_data[c*DW +: DW] = q[c][0];
                e_vld[c] = bus.pe_idle[c];
            end
            if (q[c].size() >= FULL_TH) e_bp[c % LANES] = 1'b1;
        end
        e_in = m_in[31:0]; e_out = m_out[31:0]; e_drop = m_drop[31:0];
        chk("pe_vld", bus.pe_vld, e_vld);
        chk("pe_data", bus.pe_data, e_data);
        chk("sw_bp", bus.sw_bp, e_bp);
        chk("cnt_in", cnt_in, e_in);
        chk("cnt_out", cnt_out, e_out);
        chk("cnt_drop", cnt_drop, e_drop);
        chk("overflow", overflow, m_ovf);
        chk("drained", drained, m_started && m_quiet >= QUIET);

        if (ap_rst) begin
            for (int c = 0; c < CH; c++) q[c].delete();
            m_s1v = '0; m_in = 0; m_out = 0; m_drop = 0; m_ovf = '0;
            m_started = 0; m_quiet = 0;
        end else begin
            idle_now = (m_s1v == '0) && (bus.sw_ovld == '0);
            for (int c = 0; c < CH; c++) if (q[c].size() != 0) idle_now = 0;
            n_in = 0; n_out = 0; n_drop = 0;
            for (int c = 0; c < CH; c++) begin
                if (q[c].size() > 0 && bus.pe_idle[c]) begin
                    void'(q[c].pop_front());
                    n_out++;
                end
                if (m_s1v[c]) begin
                    if ((m_s1d[c] & SMASK) == SMASK) n_drop++;
                    else if (q[c].size() < DEPTH) begin
                        q[c].push_back(m_s1d[c]);
                        n_in++;
                    end else m_ovf[c] = 1'b1;
                end
            end
            if (sys_start) begin
                m_in = 0; m_out = 0; m_drop = 0; m_ovf = '0;
                m_started = 1; m_quiet = 0;
            end else begin
                m_in = sat(m_in + n_in); m_out = sat(m_out + n_out); m_drop = sat(m_drop + n_drop);
                m_quiet = idle_now ? ((m_quiet < QUIET) ? m_quiet + 1 : QUIET) : 0;
            end
            m_s1v = bus.sw_ovld;
            for (int c = 0; c < CH; c++) m_s1d[c] = bus.sw_odata[c*DW +: DW];
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic put(input int c, input logic [DW-1:0] d);
        bus.sw_ovld = '0;
        bus.sw_ovld[c] = 1'b1;
        bus.sw_odata[c*DW +: DW] = d;
    endtask

    task automatic clr();
        bus.sw_ovld = '0;
    endtask

    task automatic start();
        sys_start = 1'b1; tick(); sys_start = 1'b0;
    endtask

    initial begin
        int idle_pct;
        logic [DW-1:0] d;
        ap_rst = 1'b1; sys_start = 1'b0;
        bus.sw_ovld = '0; bus.sw_odata = '0; bus.pe_idle = '0;
        repeat (3) tick();
        ap_rst = 1'b0; bus.pe_idle = '1;
        start();

        // two-cycle latency and sentinel drop
        put(0, 32'h0000_0005); tick(); clr(); repeat (4) tick();
        put(3, 32'h003F_FFFF); tick(); clr(); repeat (4) tick();

        // backpressure threshold on lane 0 via channel 4
        bus.pe_idle[4] = 1'b0;
        for (int i = 0; i < 22; i++) begin put(4, DW'(i + 100)); tick(); end
        clr(); repeat (3) tick();
        bus.pe_idle[4] = 1'b1; tick(); bus.pe_idle[4] = 1'b0; repeat (2) tick();
        bus.pe_idle = '1; repeat (25) tick();

        // overflow on channel 1, then cleared by sys_start
        start();
        bus.pe_idle[1] = 1'b0;
        for (int i = 0; i < 33; i++) begin put(1, DW'(i + 200)); tick(); end
        clr(); repeat (3) tick();
        start(); repeat (2) tick();
        bus.pe_idle = '1; repeat (36) tick();

        // full channel 2 written while it pops
        bus.pe_idle[2] = 1'b0;
        for (int i = 0; i < 32; i++) begin put(2, DW'(i + 300)); tick(); end
        clr(); repeat (3) tick();
        put(2, 32'hABCD_0001); tick(); clr();
        bus.pe_idle[2] = 1'b1; tick(); bus.pe_idle[2] = 1'b0; repeat (2) tick();
        bus.pe_idle = '1; repeat (40) tick();

        // drain sequence
        start();
        for (int i = 0; i < 3; i++) begin put(0, DW'(i + 7)); tick(); end
        clr(); repeat (25) tick();
        put(5, 32'h1234_5678); tick(); clr(); repeat (25) tick();

        // reset while words are buffered
        bus.pe_idle = '0;
        for (int i = 0; i < 10; i++) begin put(i % CH, DW'(i + 500)); tick(); end
        ap_rst = 1'b1; repeat (2) tick(); ap_rst = 1'b0; clr();
        bus.pe_idle = '1; repeat (5) tick();
        start(); repeat (20) tick();

        idle_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) idle_pct = $urandom_range(15, 100);
            if (i % 300 >= 260) begin
                bus.sw_ovld = '0;
                bus.pe_idle = '1;
            end else begin
                for (int c = 0; c < CH; c++) bus.pe_idle[c] = ($urandom_range(0, 99) < idle_pct);
                bus.sw_ovld = CH'($urandom) & CH'($urandom);
                for (int c = 0; c < CH; c++) begin
                    d = $urandom;
                    if ($urandom_range(0, 9) == 0) d = d | SMASK;
                    bus.sw_odata[c*DW +: DW] = d;
                end
            end
            sys_start = ($urandom_range(0, 199) == 0);
            ap_rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        ap_rst = 1'b0; sys_start = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
